// File: rtl/ext_st_unit_pkg.sv
// rtl/ext_st_unit_pkg.sv - shared types and widths for the store-side external memory unit
package ext_st_unit_pkg;

  localparam int WIDTH_DATA       = 8;
  localparam int UNIT_EXT_DATA    = 4;
  localparam int WIDTH_EXT_DATA   = WIDTH_DATA * UNIT_EXT_DATA;
  localparam int WIDTH_EXT_ADDR   = 32;
  localparam int WIDTH_EXT_LENGTH = 16;
  localparam int LENGTH_BUFF_ST   = 4;
  localparam int EXT_BEAT_BYTES   = WIDTH_EXT_DATA / 8;

  typedef logic [WIDTH_EXT_DATA-1:0] ext_io_t;
  typedef logic [UNIT_EXT_DATA-1:0]  CSel_t;
  typedef logic [WIDTH_EXT_ADDR-1:0] ext_ld_addr_t;

  typedef struct packed {
    logic                  v;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;

  typedef enum logic [1:0] {
    EXTST_IDLE,
    EXTST_RUN,
    EXTST_DRAIN,
    EXTST_DONE
  } fsm_ext_st;

  typedef struct packed {
    CSel_t   csel;
    ext_io_t data;
  } ext_st_beat_t;

endpackage

// File: rtl/ext_st_unit_fifo.sv
// rtl/ext_st_unit_fifo.sv - synchronous beat FIFO with registered storage and look-ahead free count
module ext_st_unit_fifo
  import ext_st_unit_pkg::*;
#(
  parameter  int DEPTH = LENGTH_BUFF_ST,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  ext_st_beat_t     push_beat,
  input  logic             pop,
  output ext_st_beat_t     head,
  output logic             empty,
  output logic [CNT_W-1:0] free_nxt
);

  ext_st_beat_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  assign free_nxt = CNT_W'(DEPTH) - count_nxt;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ext_st_unit.sv
// rtl/ext_st_unit.sv - packs word tokens into beats and writes them to external memory
// Optional EXT_ST_STATS_EN adds O_StallCnt (saturating count of ungranted request cycles).
module ext_st_unit
  import ext_st_unit_pkg::*;
#(
  parameter int DEPTH_BUFF = LENGTH_BUFF_ST
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Start,
  input  logic [WIDTH_EXT_ADDR-1:0]   I_Base,
  input  logic [WIDTH_EXT_LENGTH-1:0] I_Length,
  input  FTk_t                        I_FTk,
  output BTk_t                        O_BTk,
  output logic                        O_Req,
  output logic [WIDTH_EXT_ADDR-1:0]   O_Addr,
  output logic [WIDTH_EXT_DATA-1:0]   O_Data,
  output logic [UNIT_EXT_DATA-1:0]    O_CSel,
  input  logic                        I_Gnt,
  output logic                        O_Busy,
  output logic                        O_Done
`ifdef EXT_ST_STATS_EN
  ,
  output logic [15:0]                 O_StallCnt
`endif
);

  localparam int UNIT   = UNIT_EXT_DATA;
  localparam int LANE_W = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam int CNT_W  = $clog2(DEPTH_BUFF) + 1;

  fsm_ext_st                   state;
  fsm_ext_st                   state_nxt;
  logic [WIDTH_EXT_LENGTH-1:0] remaining;
  ext_io_t                     pack_data;
  CSel_t                       pack_csel;
  logic [LANE_W-1:0]           lane_cnt;
  logic                        lane_last;
  logic                        last_word;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        start_ok;
  logic                        nack;
  logic                        fifo_empty;
  logic                        fifo_low;
  logic [CNT_W-1:0]            free_nxt;
  ext_st_beat_t                push_beat;
  ext_st_beat_t                head;
  ext_ld_addr_t                addr;

  assign start_ok  = (state == EXTST_IDLE) & I_Start;
  assign accept    = (state == EXTST_RUN) & I_FTk.v & ~nack;
  assign last_word = (remaining == WIDTH_EXT_LENGTH'(1));
  assign push      = accept & (lane_last | last_word);
  assign pop       = ~fifo_empty & I_Gnt;
  assign fifo_low  = (free_nxt < CNT_W'(2));

  generate
    if (UNIT == 1) begin : g_single_lane
      assign lane_cnt  = '0;
      assign lane_last = 1'b1;
    end else begin : g_multi_lane
      assign lane_last = (lane_cnt == LANE_W'(UNIT - 1));
      always_ff @(posedge clock) begin
        if (!reset) begin
          lane_cnt <= '0;
        end else if (push) begin
          lane_cnt <= '0;
        end else if (accept) begin
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
      end
    end
  endgenerate

  // Beat as it would look with the current word merged in; this is what gets pushed.
  always_comb begin
    push_beat.data = pack_data;
    push_beat.csel = pack_csel;
    push_beat.data[lane_cnt*WIDTH_DATA +: WIDTH_DATA] = I_FTk.d;
    push_beat.csel[lane_cnt] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pack_data <= '0;
      pack_csel <= '0;
    end else if (push) begin
      pack_data <= '0;
      pack_csel <= '0;
    end else if (accept) begin
      pack_data <= push_beat.data;
      pack_csel <= push_beat.csel;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      remaining <= '0;
    end else if (start_ok) begin
      remaining <= I_Length;
    end else if (accept) begin
      remaining <= remaining - WIDTH_EXT_LENGTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= EXTST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    O_Busy    = 1'b0;
    O_Done    = 1'b0;
    case (state)
      EXTST_IDLE: begin
        if (I_Start) begin
          state_nxt = (I_Length == '0) ? EXTST_DONE : EXTST_RUN;
        end
      end
      EXTST_RUN: begin
        O_Busy = 1'b1;
        if (accept && last_word) begin
          state_nxt = EXTST_DRAIN;
        end
      end
      EXTST_DRAIN: begin
        O_Busy = 1'b1;
        if (fifo_empty && !push) begin
          state_nxt = EXTST_DONE;
        end
      end
      EXTST_DONE: begin
        O_Done    = 1'b1;
        state_nxt = EXTST_IDLE;
      end
      default: state_nxt = EXTST_IDLE;
    endcase
  end

  // Nack looks one cycle ahead so a word in flight always still has a slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      nack <= 1'b1;
    end else begin
      nack <= (state_nxt != EXTST_RUN) | fifo_low;
    end
  end

  assign O_BTk.n = nack;

  ext_st_unit_fifo #(
    .DEPTH (DEPTH_BUFF)
  ) u_fifo (
    .clk       (clock),
    .resetn    (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .free_nxt  (free_nxt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr <= '0;
    end else if (start_ok) begin
      addr <= I_Base;
    end else if (pop) begin
      addr <= addr + ext_ld_addr_t'(EXT_BEAT_BYTES);
    end
  end

  assign O_Req  = ~fifo_empty;
  assign O_Addr = addr;
  assign O_Data = fifo_empty ? '0 : head.data;
  assign O_CSel = fifo_empty ? '0 : head.csel;

`ifdef EXT_ST_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (O_Req && !I_Gnt && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign O_StallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ext_st_unit.sv
// tb/tb_ext_st_unit.sv - scoreboard bench for ext_st_unit (EXT_ST_STATS_EN adds a stall-count case)
module tb_ext_st_unit;
  import ext_st_unit_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  csel;
  } exp_t;

  logic                        clock;
  logic                        reset;
  logic                        I_Start;
  logic [WIDTH_EXT_ADDR-1:0]   I_Base;
  logic [WIDTH_EXT_LENGTH-1:0] I_Length;
  FTk_t                        I_FTk;
  BTk_t                        O_BTk;
  logic                        O_Req;
  logic [WIDTH_EXT_ADDR-1:0]   O_Addr;
  logic [WIDTH_EXT_DATA-1:0]   O_Data;
  logic [UNIT_EXT_DATA-1:0]    O_CSel;
  logic                        I_Gnt;
  logic                        O_Busy;
  logic                        O_Done;
`ifdef EXT_ST_STATS_EN
  logic [15:0]                 O_StallCnt;
`endif

  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  ext_st_unit dut (
    .clock    (clock),
    .reset    (reset),
    .I_Start  (I_Start),
    .I_Base   (I_Base),
    .I_Length (I_Length),
    .I_FTk    (I_FTk),
    .O_BTk    (O_BTk),
    .O_Req    (O_Req),
    .O_Addr   (O_Addr),
    .O_Data   (O_Data),
    .O_CSel   (O_CSel),
    .I_Gnt    (I_Gnt),
    .O_Busy   (O_Busy),
    .O_Done   (O_Done)
`ifdef EXT_ST_STATS_EN
    ,
    .O_StallCnt (O_StallCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.csel = c;
    exp_q.push_back(e);
  endtask

  // Compares the head every cycle it is offered, so a stalled beat must stay stable.
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (O_Done === 1'b1) done_cnt++;
      if (O_Req === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr 0x%0h data 0x%0h, expected no request", O_Addr, O_Data);
        end else begin
          check("req_addr", O_Addr, exp_q[0].addr);
          check("req_data", O_Data, exp_q[0].data);
          check("req_csel", O_CSel, exp_q[0].csel);
          if (I_Gnt) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] len);
    I_Base   = base;
    I_Length = len;
    I_Start  = 1'b1;
    @(posedge clock); #1;
    I_Start  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int guard = 0;
    I_FTk.v = 1'b1;
    I_FTk.d = d;
    while (O_BTk.n !== 1'b0 && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 1000) fail_now("send_word");
    else begin
      @(posedge clock); #1;
    end
    I_FTk.v = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (O_Done !== 1'b1 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_done"}, O_Done, 1);
    check({name, "_busy"}, O_Busy, 0);
    @(posedge clock); #1;
    check({name, "_done_pulse"}, O_Done, 0);
    check({name, "_done_cnt"}, done_cnt - d0, 1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req"},  O_Req, 0);
    check({name, "_addr"}, O_Addr, 0);
    check({name, "_data"}, O_Data, 0);
    check({name, "_csel"}, O_CSel, 0);
    check({name, "_busy"}, O_Busy, 0);
    check({name, "_done"}, O_Done, 0);
    check({name, "_nack"}, O_BTk.n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        saw_nack;
    logic [31:0] d;
    int          d0;

    reset    = 1'b0;
    I_Start  = 1'b0;
    I_Base   = '0;
    I_Length = '0;
    I_FTk    = '0;
    I_Gnt    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clock); #1;
    fork monitor(); join_none

    // Eight words, always granted: two full beats.
    push_exp(32'h100, 32'h04030201, 4'hF);
    push_exp(32'h104, 32'h08070605, 4'hF);
    start(32'h100, 16'd8);
    check("t1_busy", O_Busy, 1);
    for (int i = 1; i <= 8; i++) send_word(8'(i));
    wait_done("t1");

    // Five words: partial last beat; a start pulse mid-transfer is ignored.
    push_exp(32'h300, 32'hA4A3A2A1, 4'hF);
    push_exp(32'h304, 32'h000000A5, 4'h1);
    start(32'h300, 16'd5);
    send_word(8'hA1);
    send_word(8'hA2);
    I_Base   = 32'hDEAD0000;
    I_Length = 16'd1;
    I_Start  = 1'b1;
    send_word(8'hA3);
    I_Start  = 1'b0;
    send_word(8'hA4);
    send_word(8'hA5);
    wait_done("t2");

    // Zero length: done the cycle after start, no request.
    d0 = done_cnt;
    start(32'h700, 16'd0);
    check("t3_done", O_Done, 1);
    check("t3_busy", O_Busy, 0);
    @(posedge clock); #1;
    check("t3_done_pulse", O_Done, 0);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_req", O_Req, 0);

    // Grant withheld 40 cycles under continuous tokens, then 16 beats drain.
    I_Gnt = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(4*k + j + 1);
      push_exp(32'h200 + 32'(4*k), d, 4'hF);
    end
    start(32'h200, 16'd64);
    saw_nack = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) send_word(8'(i + 1));
      end
      begin
        repeat (40) begin
          @(posedge clock); #1;
          if (O_BTk.n === 1'b1) saw_nack = 1'b1;
        end
        check("t4_req_held", O_Req, 1);
        I_Gnt = 1'b1;
      end
    join
    check("t4_nack_seen", saw_nack, 1);
    wait_done("t4");

    // Reset at word 3, then a clean transfer.
    start(32'h400, 16'd8);
    send_word(8'h01);
    send_word(8'h02);
    I_FTk.v = 1'b1;
    I_FTk.d = 8'h03;
    reset   = 1'b0;
    @(posedge clock); #1;
    I_FTk.v = 1'b0;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    reset = 1'b1;
    @(posedge clock); #1;
    push_exp(32'h500, 32'h14131211, 4'hF);
    push_exp(32'h504, 32'h18171615, 4'hF);
    start(32'h500, 16'd8);
    for (int i = 0; i < 8; i++) send_word(8'(8'h11 + i));
    wait_done("t5");

`ifdef EXT_ST_STATS_EN
    // Seven ungranted request cycles.
    I_Gnt = 1'b0;
    push_exp(32'h600, 32'h34333231, 4'hF);
    start(32'h600, 16'd4);
    for (int i = 0; i < 4; i++) send_word(8'(8'h31 + i));
    begin
      int n = 0;
      while (O_Req !== 1'b1 && n < 100) begin
        @(posedge clock); #1;
        n++;
      end
      if (n >= 100) fail_now("t6_req_wait");
    end
    repeat (7) @(posedge clock);
    #1;
    I_Gnt = 1'b1;
    wait_done("t6");
    check("t6_stall_cnt", O_StallCnt, 7);
`endif

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
